// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter: response-owner
// encoding, word-alignment mask and the default starvation limit.
package sram_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_INST = 2'd1,
      OWN_DATA = 2'd2
   } owner_e;

   localparam logic [31:0] WORD_ALIGN_MASK    = 32'hFFFF_FFFC;
   localparam int unsigned STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/sram_arb_prio.sv
// Grant selection between fetch and data ports: data wins ties unless fetch
// has been denied STARVE_MAX consecutive cycles while requesting.
module sram_arb_prio
   import sram_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic i_req,
   input  logic d_req,
   output logic i_gnt,
   output logic d_gnt
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0] starve_cnt_q;
   logic [3:0] starve_cnt_d;
   logic       starved;

   always_comb begin
      starved = (starve_cnt_q == STARVE_LIM);
      i_gnt   = 1'b0;
      d_gnt   = 1'b0;
      if (!rst) begin
         if (d_req && !(i_req && starved)) begin
            d_gnt = 1'b1;
         end else if (i_req) begin
            i_gnt = 1'b1;
         end
      end

      starve_cnt_d = starve_cnt_q;
      if (i_gnt || !i_req) begin
         starve_cnt_d = '0;
      end else if (d_gnt && !starved) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between the fetch and data ports,
// steering the next-cycle read data back to whichever port owned the access.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_valid,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic [3:0]  d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_valid,
   output logic [31:0] d_rdata,
   output logic        m_en,
   output logic [3:0]  m_wen,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata
);

   owner_e      resp_owner_q, resp_owner_d;
   logic        resp_store_q, resp_store_d;
   logic [31:0] i_hold_q, i_hold_d;
   logic [31:0] d_hold_q, d_hold_d;
   logic        d_load_resp;

   sram_arb_prio #(
      .STARVE_MAX (STARVE_MAX)
   ) u_prio (
      .clk   (clk),
      .rst   (rst),
      .i_req (i_req),
      .d_req (d_req),
      .i_gnt (i_gnt),
      .d_gnt (d_gnt)
   );

   always_comb begin
      m_en    = i_gnt | d_gnt;
      m_wen   = d_gnt ? d_we : '0;
      m_wdata = d_gnt ? d_wdata : '0;
      if (d_gnt) begin
         m_addr = d_addr & WORD_ALIGN_MASK;
      end else if (i_gnt) begin
         m_addr = i_addr & WORD_ALIGN_MASK;
      end else begin
         m_addr = '0;
      end

      if (d_gnt) begin
         resp_owner_d = OWN_DATA;
      end else if (i_gnt) begin
         resp_owner_d = OWN_INST;
      end else begin
         resp_owner_d = OWN_NONE;
      end
      resp_store_d = d_gnt && (d_we != '0);

      // Gating with rst drops a response still in flight when reset lands.
      i_valid     = !rst && (resp_owner_q == OWN_INST);
      d_valid     = !rst && (resp_owner_q == OWN_DATA);
      d_load_resp = d_valid && !resp_store_q;

      i_hold_d = i_valid     ? m_rdata : i_hold_q;
      d_hold_d = d_load_resp ? m_rdata : d_hold_q;

      i_rdata = rst ? '0 : (i_valid     ? m_rdata : i_hold_q);
      d_rdata = rst ? '0 : (d_load_resp ? m_rdata : d_hold_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         resp_owner_q <= OWN_NONE;
         resp_store_q <= 1'b0;
         i_hold_q     <= '0;
         d_hold_q     <= '0;
      end else begin
         resp_owner_q <= resp_owner_d;
         resp_store_q <= resp_store_d;
         i_hold_q     <= i_hold_d;
         d_hold_q     <= d_hold_d;
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM, a spec-level
// reference model checked every cycle, and hand-computed spot checks.
module tb_sram_port_arbiter;

   localparam int unsigned SMAX = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt, i_valid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic [3:0]  d_we;
   logic [31:0] d_addr, d_wdata;
   logic        d_gnt, d_valid;
   logic [31:0] d_rdata;
   logic        m_en;
   logic [3:0]  m_wen;
   logic [31:0] m_addr, m_wdata;
   logic [31:0] m_rdata = '0;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   sram_port_arbiter #(
      .STARVE_MAX (SMAX)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .i_req   (i_req),
      .i_addr  (i_addr),
      .i_gnt   (i_gnt),
      .i_valid (i_valid),
      .i_rdata (i_rdata),
      .d_req   (d_req),
      .d_we    (d_we),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_gnt   (d_gnt),
      .d_valid (d_valid),
      .d_rdata (d_rdata),
      .m_en    (m_en),
      .m_wen   (m_wen),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_rdata (m_rdata)
   );

   // SRAM macro stand-in driven only by the DUT's memory pins.
   logic [31:0] sram [bit [29:0]];
   // Reference contents, updated by the model at each expected grant.
   logic [31:0] gold [bit [29:0]];

   always @(posedge clk) begin
      if (m_en) begin
         if (m_wen != 4'b0000) begin
            logic [31:0] w;
            w = sram.exists(m_addr[31:2]) ? sram[m_addr[31:2]] : 32'h0;
            for (int b = 0; b < 4; b++)
               if (m_wen[b]) w[b*8 +: 8] = m_wdata[b*8 +: 8];
            sram[m_addr[31:2]] = w;
         end else begin
            m_rdata <= sram.exists(m_addr[31:2]) ? sram[m_addr[31:2]] : 32'h0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] gold_rd(input logic [31:0] a);
      return gold.exists(a[31:2]) ? gold[a[31:2]] : 32'h0;
   endfunction

   // Reference model state: fetch-denial streak, pending response, held words.
   int unsigned streak = 0;
   int          pend   = 0;     // 0 none, 1 fetch, 2 data
   bit          pend_store = 1'b0;
   logic [31:0] pend_word = '0;
   logic [31:0] hold_i = '0, hold_d = '0;

   always @(negedge clk) begin
      bit eI, eD;
      logic [31:0] w;
      eI = 1'b0;
      eD = 1'b0;
      if (!rst) begin
         if (i_req && d_req) begin
            if (streak == SMAX) eI = 1'b1;
            else                eD = 1'b1;
         end else begin
            eI = i_req;
            eD = d_req;
         end
      end

      chk("i_gnt", {31'b0, i_gnt}, {31'b0, eI});
      chk("d_gnt", {31'b0, d_gnt}, {31'b0, eD});
      chk("m_en",  {31'b0, m_en},  {31'b0, eI | eD});
      chk("m_wen", {28'b0, m_wen}, {28'b0, (eD ? d_we : 4'b0000)});
      if (eD) chk("m_addr_d", m_addr, {d_addr[31:2], 2'b00});
      if (eI) chk("m_addr_i", m_addr, {i_addr[31:2], 2'b00});
      if (eD && d_we != 4'b0000) chk("m_wdata", m_wdata, d_wdata);

      chk("i_valid", {31'b0, i_valid}, {31'b0, (!rst && pend == 1)});
      chk("d_valid", {31'b0, d_valid}, {31'b0, (!rst && pend == 2)});
      chk("i_rdata", i_rdata, rst ? 32'h0 : (pend == 1 ? pend_word : hold_i));
      chk("d_rdata", d_rdata, rst ? 32'h0 : ((pend == 2 && !pend_store) ? pend_word : hold_d));

      if (rst) begin
         streak = 0;
         pend   = 0;
         hold_i = '0;
         hold_d = '0;
      end else begin
         if (pend == 1) hold_i = pend_word;
         if (pend == 2 && !pend_store) hold_d = pend_word;
         streak = (i_req && eD) ? ((streak < SMAX) ? streak + 1 : SMAX) : 0;
         if (eI) begin
            pend      = 1;
            pend_word = gold_rd(i_addr);
         end else if (eD) begin
            pend       = 2;
            pend_store = (d_we != 4'b0000);
            if (pend_store) begin
               w = gold_rd(d_addr);
               for (int b = 0; b < 4; b++)
                  if (d_we[b]) w[b*8 +: 8] = d_wdata[b*8 +: 8];
               gold[d_addr[31:2]] = w;
            end else begin
               pend_word = gold_rd(d_addr);
            end
         end else begin
            pend = 0;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] v);
      sram[a[31:2]] = v;
      gold[a[31:2]] = v;
   endtask

   initial begin
      rst = 1'b1;
      i_req = 1'b1; i_addr = 32'h0000_0040;
      d_req = 1'b1; d_we = 4'b0000; d_addr = 32'h0000_0080; d_wdata = '0;
      for (int k = 0; k < 8; k++)
         preload(32'hBFC0_0000 + 32'(k * 4), 32'h1000_0000 + 32'(k));
      preload(32'h0000_0200, 32'h1122_3344);
      preload(32'h0000_0400, 32'hCAFE_0400);

      repeat (3) cyc();
      @(negedge clk);
      chk("rst_i_gnt", {31'b0, i_gnt}, 32'h0);
      chk("rst_d_gnt", {31'b0, d_gnt}, 32'h0);
      chk("rst_m_en",  {31'b0, m_en},  32'h0);
      chk("rst_m_wen", {28'b0, m_wen}, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      cyc();
      rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      chk("post_rst_i_valid", {31'b0, i_valid}, 32'h0);
      chk("post_rst_d_valid", {31'b0, d_valid}, 32'h0);
      cyc();

      // Fetch-only stream.
      for (int k = 0; k < 6; k++) begin
         i_req = 1'b1; i_addr = 32'hBFC0_0000 + 32'(k * 4);
         @(negedge clk);
         chk("fetch_m_addr", m_addr, 32'hBFC0_0000 + 32'(k * 4));
         cyc();
      end
      i_req = 1'b0;
      @(negedge clk);
      chk("fetch_last_valid", {31'b0, i_valid}, 32'h1);
      chk("fetch_last_word", i_rdata, 32'h1000_0005);
      cyc();

      // Store then load at 0x100.
      d_req = 1'b1; d_we = 4'b1111; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
      cyc();
      d_we = 4'b0000; d_wdata = 32'h0;
      @(negedge clk);
      chk("store_valid", {31'b0, d_valid}, 32'h1);
      chk("store_rdata_unchanged", d_rdata, 32'h0);
      cyc();
      d_req = 1'b0;
      @(negedge clk);
      chk("load_rdata", d_rdata, 32'hDEAD_BEEF);
      cyc();

      // Byte store into a preloaded word.
      d_req = 1'b1; d_we = 4'b0010; d_addr = 32'h0000_0200; d_wdata = 32'h0000_AA00;
      cyc();
      d_we = 4'b0000;
      cyc();
      d_req = 1'b0;
      @(negedge clk);
      chk("byte_store_rdata", d_rdata, 32'h1122_AA44);
      cyc();

      // Contention: expect D,D,D,D,I repeating.
      i_req = 1'b1; i_addr = 32'hBFC0_0008;
      d_req = 1'b1; d_we = 4'b0000; d_addr = 32'h0000_0100;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         chk("contend_i_gnt", {31'b0, i_gnt}, {31'b0, ((c % 5) == 4)});
         cyc();
      end
      i_req = 1'b0; d_req = 1'b0;
      cyc();

      // Reset lands the cycle after a load grant.
      d_req = 1'b1; d_we = 4'b0000; d_addr = 32'h0000_0200;
      cyc();
      rst = 1'b1; i_req = 1'b1;
      @(negedge clk);
      chk("midrst_d_valid", {31'b0, d_valid}, 32'h0);
      chk("midrst_d_gnt",   {31'b0, d_gnt},   32'h0);
      chk("midrst_d_rdata", d_rdata, 32'h0);
      chk("midrst_m_en",    {31'b0, m_en},    32'h0);
      cyc();
      rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      chk("midrst_after_d_valid", {31'b0, d_valid}, 32'h0);
      cyc();

      // Misaligned fetch address is word-aligned on the SRAM side.
      i_req = 1'b1; i_addr = 32'h0000_0403;
      @(negedge clk);
      chk("misalign_m_addr", m_addr, 32'h0000_0400);
      cyc();
      i_req = 1'b0;
      @(negedge clk);
      chk("misalign_word", i_rdata, 32'hCAFE_0400);
      repeat (3) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the single-port synchronous SRAM of the SoC between the CPU instruction-fetch port and the data (load/store) port. Each cycle it grants at most one request, drives the SRAM, and routes the one-cycle-later read data back to the owner with a valid pulse. Data has priority, bounded by a starvation counter that guarantees fetch progress. It sits between the `top` datapath ports and the SRAM macro.

## Interface
- `STARVE_MAX`, 4: consecutive cycles fetch may be denied while requesting before it is forced a grant (1..15)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `i_req`  in  1  fetch request; held with `i_addr` until `i_gnt`
- `i_addr`  in  32  fetch byte address
- `i_gnt`  out  1  fetch accepted this cycle (combinational)
- `i_valid`  out  1  one-cycle pulse: `i_rdata` holds the fetched word
- `i_rdata`  out  32  fetched word
- `d_req`  in  1  data request; held with address, write enables and write data until `d_gnt`
- `d_we`  in  4  byte write enables; 4'b0000 = read
- `d_addr`  in  32  data byte address
- `d_wdata`  in  32  store data
- `d_gnt`  out  1  data accepted this cycle (combinational)
- `d_valid`  out  1  one-cycle pulse: load data ready or store complete
- `d_rdata`  out  32  load data
- `m_en`  out  1  SRAM enable
- `m_wen`  out  4  SRAM byte write enables
- `m_addr`  out  32  SRAM word address, `{addr[31:2],2'b00}`
- `m_wdata`  out  32  SRAM write data
- `m_rdata`  in  32  SRAM read data, valid the cycle after `m_en`

## Operation
- Grant rule, evaluated each cycle with `rst`=0:
  - Fetch only requests: `i_gnt`=1.
  - Data only requests: `d_gnt`=1.
  - Both request: `d_gnt`=1, unless `starve_cnt`==`STARVE_MAX`, which gives `i_gnt`=1.
  - At most one grant per cycle.
- `starve_cnt` (4 bits):
  - Increments when `i_req`=1 and `d_gnt`=1.
  - Clears on any `i_gnt`, or when `i_req`=0.
  - Saturates at `STARVE_MAX`.
- SRAM drive: `m_en`=`i_gnt|d_gnt`; the granted port's address goes to `m_addr`. `m_wen`=`d_we` when data is granted, else 0. `m_wdata`=`d_wdata` (don't-care on reads).
- `resp_owner` register (NONE/INST/DATA) is loaded each cycle with the granted port, or NONE.
- Response cycle (the cycle after a grant):
  - `i_valid`=1 if `resp_owner`==INST; `d_valid`=1 if `resp_owner`==DATA. This applies to stores too.
  - The owner's rdata output is combinationally `m_rdata` and is captured into that port's hold register.
  - Outside its response cycle, each rdata output shows its hold register.
  - Store responses do not update `d_rdata`.
- Back-to-back operation is allowed: a new grant can occur in the same cycle as the previous response. Throughput is 1 access/cycle.

## Timing
- Request to grant: 0 cycles. Grant to valid: 1 cycle. Store takes effect at the grant edge.
- Reset values: `i_gnt`, `d_gnt`, `m_en`, `i_valid`, `d_valid` = 0; `m_wen`=0; `i_rdata`, `d_rdata`, hold registers = 0; `starve_cnt`=0; `resp_owner`=NONE.
- While `rst`=1, all grants are forced to 0 regardless of requests.
- Reset mid-operation: an outstanding response is dropped. No valid pulse occurs in the first cycle after `rst` falls.
- Requester rule: `addr`/`we`/`wdata` must not change while `req`=1 and `gnt`=0. The arbiter does not check this.
- A request dropped before grant is legal and produces no access.

## Structure
- Package `sram_arb_pkg` holds:
  - owner encoding: `OWN_NONE`=2'd0, `OWN_INST`=2'd1, `OWN_DATA`=2'd2;
  - `WORD_ALIGN_MASK`=32'hFFFF_FFFC;
  - the default for `STARVE_MAX`.
- One sub-module, `sram_arb_prio`:
  - Inputs: `clk`, `rst`, `i_req`, `d_req`.
  - Outputs: `i_gnt`, `d_gnt`.
  - Owns `starve_cnt`.
- The top level contains the SRAM muxing, `resp_owner` and the hold registers.

## Test plan
- Fetch-only stream: `i_req`=1 with `i_addr` 0xBFC00000, 0xBFC00004, … → `i_gnt`=1 every cycle, `m_addr` follows `i_addr`, and `i_valid` goes high one cycle after each grant with the preloaded word.
- Store then load: store `d_we`=4'b1111, `d_addr`=0x100, `d_wdata`=0xDEADBEEF; next cycle load from 0x100 → store `d_valid` pulse with `d_rdata` unchanged, then load `d_rdata`=0xDEADBEEF.
- Byte store: preload 0x11223344 at 0x200; store `d_we`=4'b0010, `d_wdata`=0x0000AA00; read back → 0x1122AA44.
- Contention, `STARVE_MAX`=4: `i_req` and `d_req` held high → grant pattern D,D,D,D,I repeating; `i_valid` once every 5 cycles.
- Reset mid-access: grant a load at cycle t, assert `rst` at t+1 → no `d_valid`, all outputs 0, no grant until `rst` falls.
- Misaligned address: `i_addr`=0x00000403 → `m_addr`=0x00000400.
